// File: rtl/eject_if.sv
// Handshake bundle between the ring router, the eject buffer and the node.
// The master side is the router/node environment; the slave side is the buffer.
interface eject_if #(
  parameter int W     = 144,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  eject;
  logic          push;
  logic          bfull;
  logic [W-1:0]  flit_out;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   ejected_cnt;

  modport master (
    output eject, push, out_ready,
    input  bfull, flit_out, out_valid, count, overflow, ejected_cnt
  );

  modport slave (
    input  eject, push, out_ready,
    output bfull, flit_out, out_valid, count, overflow, ejected_cnt
  );
endinterface

// File: rtl/eject_buffer.sv
// Circular FIFO that absorbs flits ejected by a ring router and hands them to the node.
// bfull rises one slot early so a push issued alongside its rise still fits.
module eject_buffer #(
  parameter int DEPTH = 4,
  parameter int W     = 144
) (
  input  logic  clk,
  input  logic  rst,
  eject_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          bfull_q, bfull_d;
  logic          out_valid_q, out_valid_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   ejected_cnt_q, ejected_cnt_d;
  logic          pop_s;
  logic          full_s;
  logic          wr_en_s;

  // Next-state logic: a push into a full buffer is dropped even when a pop frees a slot.
  always_comb begin
    full_s        = (count_q == CW'(DEPTH));
    pop_s         = out_valid_q && bus.out_ready;
    wr_en_s       = bus.push && !full_s;
    overflow_d    = overflow_q || (bus.push && full_s);
    rd_ptr_d      = pop_s   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d      = wr_en_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    ejected_cnt_d = pop_s   ? ejected_cnt_q + 16'd1 : ejected_cnt_q;
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    bfull_d     = (count_d >= CW'(DEPTH - 1));
    out_valid_d = (count_d != CW'(0));
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      bfull_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      overflow_q    <= 1'b0;
      ejected_cnt_q <= 16'd0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      bfull_q       <= bfull_d;
      out_valid_q   <= out_valid_d;
      overflow_q    <= overflow_d;
      ejected_cnt_q <= ejected_cnt_d;
    end
  end

  // Flit storage; contents survive reset and are masked off while empty.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= bus.eject;
    end
  end

  assign bus.flit_out    = out_valid_q ? mem_q[rd_ptr_q] : '0;
  assign bus.out_valid   = out_valid_q;
  assign bus.bfull       = bfull_q;
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.ejected_cnt = ejected_cnt_q;
endmodule

// File: tb/tb_eject_buffer.sv
// Self-checking bench for eject_buffer: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_eject_buffer;
  localparam int DEPTH = 4;
  localparam int W     = 144;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eject_if #(.W(W), .DEPTH(DEPTH)) bus ();
  eject_buffer #(.DEPTH(DEPTH), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq [$];
  bit           m_ovf;
  logic [15:0]  m_ej;
  bit           m_bfull;

  function automatic logic [W-1:0] rand_flit();
    return W'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_ej    = 16'd0;
    m_bfull = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] exp_flit;
    exp_flit = (mq.size() != 0) ? mq[0] : '0;
    chk({tag, ".count"},     W'(bus.count),       W'(mq.size()));
    chk({tag, ".out_valid"}, W'(bus.out_valid),   W'(mq.size() != 0));
    chk({tag, ".flit_out"},  bus.flit_out,        exp_flit);
    chk({tag, ".bfull"},     W'(bus.bfull),       W'(m_bfull));
    chk({tag, ".overflow"},  W'(bus.overflow),    W'(m_ovf));
    chk({tag, ".ejected"},   W'(bus.ejected_cnt), W'(m_ej));
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, settle 1ns.
  task automatic cycle(input bit p, input logic [W-1:0] d, input bit r);
    int sz;
    @(negedge clk);
    bus.push      = p;
    bus.eject     = d;
    bus.out_ready = r;
    @(posedge clk);
    sz = mq.size();
    if (p && sz == DEPTH) m_ovf = 1'b1;
    if (r && sz > 0) begin
      void'(mq.pop_front());
      m_ej = m_ej + 16'd1;
    end
    if (p && sz < DEPTH) mq.push_back(d);
    m_bfull = (mq.size() >= DEPTH - 1);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.push      = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  logic [W-1:0] fa, fb, fc, fd, fe;

  initial begin
    bus.push      = 1'b0;
    bus.eject     = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single flit latency
    cycle(1'b1, 144'h011111111111111111111111111111111854, 1'b0);
    chk("single.flit", bus.flit_out, 144'h011111111111111111111111111111111854);
    chk("single.count", W'(bus.count), W'(1));
    chk("single.bfull", W'(bus.bfull), W'(0));
    check_all("single");

    // Fill, early bfull, then overflow
    do_reset();
    fa = rand_flit(); fb = rand_flit(); fc = rand_flit(); fd = rand_flit(); fe = rand_flit();
    cycle(1'b1, fa, 1'b0); check_all("fill.a");
    cycle(1'b1, fb, 1'b0); check_all("fill.b");
    cycle(1'b1, fc, 1'b0); check_all("fill.c");
    chk("fill.c.bfull", W'(bus.bfull), W'(1));
    cycle(1'b1, fd, 1'b0); check_all("fill.d");
    chk("fill.d.count", W'(bus.count), W'(4));
    chk("fill.d.ovf", W'(bus.overflow), W'(0));
    cycle(1'b1, fe, 1'b0); check_all("fill.e");
    chk("fill.e.ovf", W'(bus.overflow), W'(1));
    chk("fill.e.count", W'(bus.count), W'(4));

    // Drain order
    chk("drain.head_a", bus.flit_out, fa);
    cycle(1'b0, '0, 1'b1); chk("drain.b", bus.flit_out, fb); check_all("drain1");
    cycle(1'b0, '0, 1'b1); chk("drain.c", bus.flit_out, fc); check_all("drain2");
    cycle(1'b0, '0, 1'b1); chk("drain.d", bus.flit_out, fd); check_all("drain3");
    cycle(1'b0, '0, 1'b1); check_all("drain4");
    chk("drain.ejected", W'(bus.ejected_cnt), W'(4));
    chk("drain.empty", W'(bus.out_valid), W'(0));

    // Concurrent push and pop at count=2
    do_reset();
    cycle(1'b1, rand_flit(), 1'b0);
    cycle(1'b1, rand_flit(), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, rand_flit(), 1'b1);
      check_all("concurrent");
      chk("concurrent.count2", W'(bus.count), W'(2));
    end

    // Asynchronous reset between edges with count=3 and overflow set
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, rand_flit(), 1'b0);
    cycle(1'b0, '0, 1'b1);
    check_all("pre_arst");
    chk("pre_arst.ovf", W'(bus.overflow), W'(1));
    @(negedge clk);
    bus.push      = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("arst");
    #1;
    rst = 1'b0;
    cycle(1'b1, rand_flit(), 1'b0);
    check_all("post_arst");
    chk("post_arst.count", W'(bus.count), W'(1));

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), rand_flit(), bit'($urandom_range(0, 1)));
      check_all("random");
    end

    // Delivered-flit counter wrap
    do_reset();
    for (int i = 0; i < 70000 && m_ej != 16'hFFFF; i++) begin
      cycle(1'b1, W'(i), 1'b1);
    end
    chk("wrap.pre", W'(bus.ejected_cnt), W'(16'hFFFF));
    cycle(1'b0, '0, 1'b1);
    chk("wrap.post", W'(bus.ejected_cnt), W'(16'h0000));
    check_all("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eject_buffer.md
EJECT_BUFFER -- requirements
Module: eject_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of flit entries; SHALL be a power of two, at least 2.
REQ-002 Parameter W, default 144, flit width; SHALL equal the router control_w width.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 eject  input  W  flit ejected by the upstream ring router.
REQ-006 push  input  1  write strobe; eject is valid this cycle.
REQ-007 bfull  output  1  backpressure to the router; while high, the router SHALL NOT assert push on the next cycle.
REQ-008 flit_out  output  W  head-of-queue flit to the node.
REQ-009 out_valid  output  1  flit_out is valid.
REQ-010 out_ready  input  1  node consumes flit_out when out_valid and out_ready are both high.
REQ-011 count  output  log2(DEPTH)+1  current occupancy.
REQ-012 overflow  output  1  sticky error flag: a push arrived while the buffer was full.
REQ-013 ejected_cnt  output  16  count of flits delivered to the node, wrapping.

Function
REQ-014 Storage SHALL be a circular FIFO with rd_ptr and wr_ptr, each log2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-015 Write: on push with count<DEPTH, eject SHALL be stored at wr_ptr and wr_ptr SHALL increment.
REQ-016 Read: on out_valid and out_ready, rd_ptr SHALL increment and ejected_cnt SHALL increment, wrapping 0xFFFF to 0x0000.
REQ-017 out_valid SHALL equal (count!=0); flit_out SHALL be driven combinationally from entry rd_ptr.
REQ-018 Latency: a flit pushed into an empty buffer SHALL appear on flit_out with out_valid high in the cycle after the push edge. There is no bypass path.
REQ-019 bfull SHALL be a registered output, high when the next-state count is at least DEPTH-1. This reserves one slot for a push issued in the same cycle bfull rises.
REQ-020 Simultaneous push and pop:
- when not full, both SHALL take effect and count SHALL be unchanged;
- when full (count==DEPTH), the pop SHALL take effect, the push SHALL be dropped and overflow SHALL be set.
REQ-021 Push with count==DEPTH and no pop: the flit SHALL be discarded, the pointers SHALL be unchanged and overflow SHALL be set.
REQ-022 overflow SHALL remain high until reset.
REQ-023 A pop with count==0 SHALL be ignored, since out_valid is low.
REQ-024 count SHALL never exceed DEPTH and never underflow.
REQ-025 The flit contents SHALL be stored unmodified; no header field is decoded.

Reset
REQ-026 While rst is high, asynchronously:
- rd_ptr=0, wr_ptr=0, count=0;
- bfull=0, out_valid=0, overflow=0, ejected_cnt=0.
REQ-027 flit_out SHALL read as 0 after reset.
REQ-028 Storage contents need not be cleared by reset.
REQ-029 Reset asserted mid-operation SHALL discard all queued flits. The first push after rst falls SHALL be accepted.

Verification
REQ-030 Single flit: push flit 144'h011111111111111111111111111111111854 with out_ready=0 -> next cycle out_valid=1, flit_out equals the pushed flit, count=1, bfull=0.
REQ-031 Fill with DEPTH=4 and out_ready=0:
- push A, B, C on consecutive cycles -> bfull=1 after C (count=3);
- push D -> count=4, overflow=0;
- push E -> E dropped, overflow=1, count=4.
REQ-032 Drain order: from the REQ-031 state, assert out_ready -> flit_out shows A, B, C, D on consecutive cycles, ejected_cnt=4, out_valid=0 after D.
REQ-033 Concurrent push and pop: with count=2, hold push and out_ready high for 10 cycles -> count stays 2, 10 flits popped in push order, pointers wrap correctly.
REQ-034 Async reset: with count=3 and overflow=1, pulse rst between clock edges -> all outputs go to their reset values immediately without waiting for a clock edge; the next push yields count=1.
REQ-035 Counter wrap: preload ejected_cnt to 0xFFFF, pop one flit -> ejected_cnt=0x0000.
